// File: rtl/hdmi_pattern_pkg.sv
// hdmi_pattern_pkg: shared modes, colour constants and helpers for the HDMI pattern generator
// Contents:
//   CW              coordinate/counter width used for h/v positions and logo coordinates
//   mode_t          output mode: black, colour bars, logo, bars with keyed logo
//   ycbcr_t         one 4:2:2 colour as {Y, Cb, Cr}
//   BAR_*           the four colour-bar colours, left to right
//   BLANK_Y/C       black / blanking level
//   in_span()       true when p lies in [lo, lo+len-1], overflow-safe
package hdmi_pattern_pkg;

   localparam int CW = 13;

   typedef enum logic [1:0] {
      MODE_BLACK     = 2'd0,
      MODE_BARS      = 2'd1,
      MODE_LOGO      = 2'd2,
      MODE_BARS_LOGO = 2'd3
   } mode_t;

   typedef struct packed {
      logic [7:0] y;
      logic [7:0] cb;
      logic [7:0] cr;
   } ycbcr_t;

   localparam ycbcr_t BAR_RED   = '{y: 8'd81,  cb: 8'd90,  cr: 8'd240};
   localparam ycbcr_t BAR_GREEN = '{y: 8'd145, cb: 8'd54,  cr: 8'd34};
   localparam ycbcr_t BAR_BLUE  = '{y: 8'd41,  cb: 8'd240, cr: 8'd110};
   localparam ycbcr_t BAR_WHITE = '{y: 8'd235, cb: 8'd128, cr: 8'd128};

   localparam logic [7:0] BLANK_Y = 8'd16;
   localparam logic [7:0] BLANK_C = 8'd128;

   // one extra bit so lo+len cannot wrap for windows near the top of the coordinate range
   function automatic logic in_span(input logic [CW-1:0] p, input logic [CW-1:0] lo,
                                    input logic [CW-1:0] len);
      return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + {1'b0, len}));
   endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// hdmi_timing_counter: raster position counters with registered sync and enable
// Ports:
//   pixel_clk, reset_n       clock, asynchronous active-low reset
//   o_h_cnt, o_v_cnt         current raster position
//   o_h_nxt, o_v_nxt         position the counters take on the next edge (look-ahead)
//   o_de, o_hs, o_vs         enable/syncs for the current position, one register stage late
//   o_first                  first pixel of frame flag, same stage as o_de
module hdmi_timing_counter
   import hdmi_pattern_pkg::*;
#(
   parameter int H_ACTIVE = 1280,
   parameter int H_FRONT  = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BACK   = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FRONT  = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BACK   = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
)(
   input  logic          pixel_clk,
   input  logic          reset_n,
   output logic [CW-1:0] o_h_cnt,
   output logic [CW-1:0] o_v_cnt,
   output logic [CW-1:0] o_h_nxt,
   output logic [CW-1:0] o_v_nxt,
   output logic          o_de,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_first
);

   localparam logic [CW-1:0] HT   = CW'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
   localparam logic [CW-1:0] VT   = CW'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
   localparam logic [CW-1:0] HA   = CW'(H_ACTIVE);
   localparam logic [CW-1:0] VA   = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_S = CW'(H_ACTIVE + H_FRONT);
   localparam logic [CW-1:0] HS_E = CW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_S = CW'(V_ACTIVE + V_FRONT);
   localparam logic [CW-1:0] VS_E = CW'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [CW-1:0] r_h, r_v, w_h_nxt, w_v_nxt;
   logic          w_h_wrap, w_vs_on;

   assign w_h_wrap = (r_h == HT - 1'b1);
   assign w_h_nxt  = w_h_wrap ? '0 : r_h + 1'b1;
   assign w_v_nxt  = !w_h_wrap ? r_v : (r_v == VT - 1'b1) ? '0 : r_v + 1'b1;

   // vsync edges land on the hsync leading edge of the first and last sync lines
   assign w_vs_on = ((r_v > VS_S) || ((r_v == VS_S) && (r_h >= HS_S))) &&
                    ((r_v < VS_E) || ((r_v == VS_E) && (r_h < HS_S)));

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h     <= '0;
         r_v     <= '0;
         o_de    <= 1'b0;
         o_hs    <= ~HS_POL;
         o_vs    <= ~VS_POL;
         o_first <= 1'b0;
      end else begin
         r_h     <= w_h_nxt;
         r_v     <= w_v_nxt;
         o_de    <= (r_h < HA) && (r_v < VA);
         o_hs    <= ((r_h >= HS_S) && (r_h < HS_E)) ? HS_POL : ~HS_POL;
         o_vs    <= w_vs_on ? VS_POL : ~VS_POL;
         o_first <= (r_h == '0) && (r_v == '0);
      end
   end

   assign o_h_cnt = r_h;
   assign o_v_cnt = r_v;
   assign o_h_nxt = w_h_nxt;
   assign o_v_nxt = w_v_nxt;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: YCbCr 4:2:2 test-pattern source with colour bars and a ROM logo overlay
// Ports:
//   pixel_clk, reset_n                 clock, asynchronous active-low reset
//   cfg_valid, cfg_mode,
//   cfg_logo_x, cfg_logo_y             config strobe; takes effect at the next frame start
//   logo_addr / logo_q                 external logo ROM, 1-cycle read latency
//   data_enable, hsync, vsync          video timing, aligned with the pixel data
//   data_Y, data_Cb_Cr                 luma and interleaved Cb/Cr
//   frame_start                        pulse on the first active pixel of a frame
// All outputs trail the raster counters by two register stages.
module hdmi_pattern_gen
   import hdmi_pattern_pkg::*;
#(
   parameter int H_ACTIVE = 1280,
   parameter int H_FRONT  = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BACK   = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FRONT  = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BACK   = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int LOGO_W   = 102,
   parameter int LOGO_H   = 35,
   parameter int AW       = 12
)(
   input  logic          pixel_clk,
   input  logic          reset_n,
   input  logic          cfg_valid,
   input  logic [1:0]    cfg_mode,
   input  logic [CW-1:0] cfg_logo_x,
   input  logic [CW-1:0] cfg_logo_y,
   output logic [AW-1:0] logo_addr,
   input  logic [15:0]   logo_q,
   output logic          data_enable,
   output logic          hsync,
   output logic          vsync,
   output logic [7:0]    data_Y,
   output logic [7:0]    data_Cb_Cr,
   output logic          frame_start
);

   localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] LW  = CW'(LOGO_W);
   localparam logic [CW-1:0] LH  = CW'(LOGO_H);
   localparam logic [CW-1:0] BW1 = CW'(H_ACTIVE / 4);
   localparam logic [CW-1:0] BW2 = CW'(2 * (H_ACTIVE / 4));
   localparam logic [CW-1:0] BW3 = CW'(3 * (H_ACTIVE / 4));

   logic [CW-1:0] w_h, w_v, w_hn, w_vn;
   logic          w_de1, w_hs1, w_vs1, w_fs1;

   hdmi_timing_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FRONT  (H_FRONT),
      .H_SYNC   (H_SYNC),
      .H_BACK   (H_BACK),
      .V_ACTIVE (V_ACTIVE),
      .V_FRONT  (V_FRONT),
      .V_SYNC   (V_SYNC),
      .V_BACK   (V_BACK),
      .HS_POL   (HS_POL),
      .VS_POL   (VS_POL)
   ) u_timing (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .o_h_cnt   (w_h),
      .o_v_cnt   (w_v),
      .o_h_nxt   (w_hn),
      .o_v_nxt   (w_vn),
      .o_de      (w_de1),
      .o_hs      (w_hs1),
      .o_vs      (w_vs1),
      .o_first   (w_fs1)
   );

   // configuration: shadow copy plus the copy in effect for the current frame
   mode_t         r_mode, r_s_mode, w_mode_n, r_mode1;
   logic [CW-1:0] r_lx, r_ly, r_s_lx, r_s_ly, w_lx_n, w_ly_n;
   logic          w_bound;

   // the edge entering (0,0) loads the new frame's config; a strobe on that same
   // edge is the latest one before the boundary, so it bypasses the shadow
   assign w_bound  = (w_hn == '0) && (w_vn == '0);
   assign w_mode_n = !w_bound ? r_mode : cfg_valid ? mode_t'(cfg_mode) : r_s_mode;
   assign w_lx_n   = !w_bound ? r_lx : cfg_valid ? cfg_logo_x : r_s_lx;
   assign w_ly_n   = !w_bound ? r_ly : cfg_valid ? cfg_logo_y : r_s_ly;

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s_mode <= MODE_BARS;
         r_s_lx   <= '0;
         r_s_ly   <= '0;
      end else if (cfg_valid) begin
         r_s_mode <= mode_t'(cfg_mode);
         r_s_lx   <= cfg_logo_x;
         r_s_ly   <= cfg_logo_y;
      end
   end

   // logo addressing runs on the look-ahead position so the ROM word for a pixel
   // arrives exactly when that pixel reaches the output stage
   logic [AW-1:0] r_row, w_row_n, w_addr_n;
   logic          w_win_n, w_win;

   assign w_win_n  = in_span(w_hn, w_lx_n, LW) && in_span(w_vn, w_ly_n, LH) &&
                     (w_hn < HA) && (w_vn < VA);
   // row base restarts on the logo's top line and steps by LOGO_W on every later line
   assign w_row_n  = (w_vn == w_ly_n) ? '0 : (w_hn == '0) ? r_row + AW'(LOGO_W) : r_row;
   assign w_addr_n = w_win_n ? w_row_n + AW'(w_hn - w_lx_n) : '0;

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode    <= MODE_BARS;
         r_lx      <= '0;
         r_ly      <= '0;
         r_row     <= '0;
         logo_addr <= '0;
      end else begin
         r_mode    <= w_mode_n;
         r_lx      <= w_lx_n;
         r_ly      <= w_ly_n;
         r_row     <= w_row_n;
         logo_addr <= w_addr_n;
      end
   end

   // stage 1: bar colour and window flag for the current position
   ycbcr_t     w_bar;
   logic       r_win1;
   logic [7:0] r_by1, r_bc1;

   assign w_win = in_span(w_h, r_lx, LW) && in_span(w_v, r_ly, LH) && (w_h < HA) && (w_v < VA);
   assign w_bar = (w_h < BW1) ? BAR_RED : (w_h < BW2) ? BAR_GREEN :
                  (w_h < BW3) ? BAR_BLUE : BAR_WHITE;

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_win1  <= 1'b0;
         r_mode1 <= MODE_BARS;
         r_by1   <= BLANK_Y;
         r_bc1   <= BLANK_C;
      end else begin
         r_win1  <= w_win;
         r_mode1 <= r_mode;
         r_by1   <= w_bar.y;
         // active lines start at h=0, so even h is Cb and every line restarts on Cb
         r_bc1   <= w_h[0] ? w_bar.cr : w_bar.cb;
      end
   end

   // stage 2: pick logo, bar or black; a zero ROM word is the transparent key in mode 3
   logic       w_logo_hit, w_bar_on;
   logic [7:0] w_y, w_c;

   assign w_logo_hit = r_win1 && ((r_mode1 == MODE_LOGO) ||
                                  ((r_mode1 == MODE_BARS_LOGO) && (logo_q != 16'h0000)));
   assign w_bar_on   = (r_mode1 == MODE_BARS) || (r_mode1 == MODE_BARS_LOGO);
   assign w_y = !w_de1 ? BLANK_Y : w_logo_hit ? logo_q[7:0]  : w_bar_on ? r_by1 : BLANK_Y;
   assign w_c = !w_de1 ? BLANK_C : w_logo_hit ? logo_q[15:8] : w_bar_on ? r_bc1 : BLANK_C;

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         data_enable <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         frame_start <= 1'b0;
         data_Y      <= BLANK_Y;
         data_Cb_Cr  <= BLANK_C;
      end else begin
         data_enable <= w_de1;
         hsync       <= w_hs1;
         vsync       <= w_vs1;
         frame_start <= w_fs1;
         data_Y      <= w_y;
         data_Cb_Cr  <= w_c;
      end
   end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: scoreboard bench for the HDMI pattern generator on a 22x11 raster
module tb_hdmi_pattern_gen;

   localparam int HT = 22;
   localparam int VT = 11;
   localparam int FR = HT * VT;

   logic        pixel_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic [12:0] cfg_logo_x = 13'd0;
   logic [12:0] cfg_logo_y = 13'd0;
   logic [3:0]  logo_addr;
   logic [15:0] logo_q = 16'h0;
   logic        data_enable, hsync, vsync, frame_start;
   logic [7:0]  data_Y, data_Cb_Cr;

   logic [15:0] rom [16];
   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;

   int by_t  [4] = '{81, 145, 41, 235};
   int bcb_t [4] = '{90, 54, 240, 128};
   int bcr_t [4] = '{240, 34, 110, 128};

   typedef struct {int due; logic [19:0] v; int h; int l;} pix_e;
   typedef struct {int due; logic [3:0] a; int h; int l;} addr_e;
   pix_e  q_pix[$];
   addr_e q_addr[$];
   pix_e  mp;
   addr_e ma;

   hdmi_pattern_gen #(
      .H_ACTIVE (16), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
      .V_ACTIVE (8),  .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
      .HS_POL   (1'b0), .VS_POL (1'b0),
      .LOGO_W   (4), .LOGO_H (2), .AW (4)
   ) dut (
      .pixel_clk   (pixel_clk),
      .reset_n     (reset_n),
      .cfg_valid   (cfg_valid),
      .cfg_mode    (cfg_mode),
      .cfg_logo_x  (cfg_logo_x),
      .cfg_logo_y  (cfg_logo_y),
      .logo_addr   (logo_addr),
      .logo_q      (logo_q),
      .data_enable (data_enable),
      .hsync       (hsync),
      .vsync       (vsync),
      .data_Y      (data_Y),
      .data_Cb_Cr  (data_Cb_Cr),
      .frame_start (frame_start)
   );

   always #5 pixel_clk = ~pixel_clk;

   always @(posedge pixel_clk or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else cyc <= cyc + 1;

   // logo ROM with one cycle of read latency
   always @(posedge pixel_clk) logo_q <= rom[logo_addr];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic in_win(int h, int v, int lx, int ly);
      return h < 16 && v < 8 && h >= lx && h < lx + 4 && v >= ly && v < ly + 2;
   endfunction

   // expected {de, hs, vs, fs, Y, CbCr} for raster position (h, v)
   function automatic logic [19:0] model(int h, int v, int md, int lx, int ly);
      logic de, hs, vs, fs, win;
      logic [15:0] q;
      logic [7:0] y, c;
      int b;
      de  = h < 16 && v < 8;
      hs  = !(h >= 18 && h < 20);
      vs  = !((v == 9 && h >= 18) || (v == 10 && h < 18));
      fs  = h == 0 && v == 0;
      win = in_win(h, v, lx, ly);
      q   = win ? rom[4'((v - ly) * 4 + (h - lx))] : 16'h0;
      b   = de ? h / 4 : 0;
      y   = 8'd16;
      c   = 8'd128;
      if (de && (md == 1 || (md == 3 && !(win && q != 16'h0)))) begin
         y = 8'(by_t[b]);
         c = 8'((h % 2 == 1) ? bcr_t[b] : bcb_t[b]);
      end
      if (de && win && (md == 2 || (md == 3 && q != 16'h0))) begin
         y = q[7:0];
         c = q[15:8];
      end
      return {de, hs, vs, fs, y, c};
   endfunction

   task automatic pulse(int md, int x, int y);
      cfg_valid  = 1'b1;
      cfg_mode   = 2'(md);
      cfg_logo_x = 13'(x);
      cfg_logo_y = 13'(y);
   endtask

   // drives n pixel cycles starting right after reset release and queues expectations
   task automatic run(int n, bit with_cfg);
      int md = 1, lx = 0, ly = 0, smd = 1, slx = 0, sly = 0;
      for (int p = 0; p < n; p++) begin
         int h, v;
         h = p % HT;
         v = (p / HT) % VT;
         if (p % FR == 0) begin
            md = smd;
            lx = slx;
            ly = sly;
         end
         cfg_valid = 1'b0;
         if (with_cfg) begin
            if (p == 100) pulse(2, 14, 7);
            else if (p == FR + 100) pulse(0, 3, 3);
            else if (p == 2 * FR - 1) pulse(3, 1, 2);
            else if (p == 2 * FR + 50) pulse(2, 20, 20);
            else if (p == 3 * FR) pulse(2, 13, 6);
            else if (p == 4 * FR + 30) pulse(0, 0, 0);
         end
         if (p == 0) q_pix.push_back('{1, 20'h61080, -1, -1});
         q_pix.push_back('{p + 2, model(h, v, md, lx, ly), h, v});
         if (in_win(h, v, lx, ly)) q_addr.push_back('{p, 4'((v - ly) * 4 + (h - lx)), h, v});
         if (cfg_valid) begin
            smd = int'(cfg_mode);
            slx = int'(cfg_logo_x);
            sly = int'(cfg_logo_y);
         end
         @(posedge pixel_clk);
         #1;
      end
      cfg_valid = 1'b0;
   endtask

   always @(negedge pixel_clk) begin
      if (reset_n) begin
         if (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
            ma = q_addr.pop_front();
            if (ma.due != cyc) chk($sformatf("addr_late h=%0d v=%0d", ma.h, ma.l), 32'(cyc), 32'(ma.due));
            else chk($sformatf("addr h=%0d v=%0d", ma.h, ma.l), 32'(logo_addr), 32'(ma.a));
         end
         if (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
            mp = q_pix.pop_front();
            if (mp.due != cyc) chk($sformatf("pix_late h=%0d v=%0d", mp.h, mp.l), 32'(cyc), 32'(mp.due));
            else chk($sformatf("pix h=%0d v=%0d", mp.h, mp.l),
                     32'({data_enable, hsync, vsync, frame_start, data_Y, data_Cb_Cr}), 32'(mp.v));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = {8'(200 + i), 8'(60 + i)};
      rom[2] = 16'h0000;
      repeat (3) @(posedge pixel_clk);
      #1;
      chk("reset_out", 32'({data_enable, hsync, vsync, frame_start, data_Y, data_Cb_Cr}), 32'h61080);
      chk("reset_addr", 32'(logo_addr), 32'h0);
      reset_n = 1'b1;
      run(4 * FR + 53, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_out", 32'({data_enable, hsync, vsync, frame_start, data_Y, data_Cb_Cr}), 32'h61080);
      chk("midreset_addr", 32'(logo_addr), 32'h0);
      q_pix.delete();
      q_addr.delete();
      repeat (3) @(posedge pixel_clk);
      #1;
      reset_n = 1'b1;
      run(2 * FR + 10, 1'b0);
      repeat (3) @(posedge pixel_clk);
      #1;
      chk("drain", 32'(q_pix.size() + q_addr.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
